// File: rtl/div_pkg.sv
// Shared definitions for the iterative radix-4 divider: FSM state encoding
// and the leading-zero skip sizes.
package div_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int SKIP_16 = 16;
  localparam int SKIP_8  = 8;
  localparam int SKIP_4  = 4;

endpackage

// File: rtl/div_r4_step.sv
// One restoring radix-4 iteration: picks the largest divisor multiple (0..3)
// not exceeding the shifted partial remainder and returns 2 quotient bits.
module div_r4_step
  import div_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH+1:0] rem_in,
  input  logic [WIDTH+1:0] d1,
  input  logic [WIDTH+1:0] d2,
  input  logic [WIDTH+1:0] d3,
  output logic [WIDTH-1:0] rem_out,
  output logic [1:0]       quo_bits
);

  // One guard bit above the WIDTH+2 operands keeps every difference exact.
  logic signed [WIDTH+2:0] pr;
  logic signed [WIDTH+2:0] s1;
  logic signed [WIDTH+2:0] s2;
  logic signed [WIDTH+2:0] s3;
  logic signed [WIDTH+2:0] sel;

  always_comb begin
    pr = $signed({1'b0, rem_in});
    s1 = pr - $signed({1'b0, d1});
    s2 = pr - $signed({1'b0, d2});
    s3 = pr - $signed({1'b0, d3});
    if (!s3[WIDTH+2]) begin
      sel      = s3;
      quo_bits = 2'd3;
    end else if (!s2[WIDTH+2]) begin
      sel      = s2;
      quo_bits = 2'd2;
    end else if (!s1[WIDTH+2]) begin
      sel      = s1;
      quo_bits = 2'd1;
    end else begin
      sel      = pr;
      quo_bits = 2'd0;
    end
    rem_out = WIDTH'(sel);
  end

endmodule

// File: rtl/param_div.sv
// Iterative signed/unsigned divider: magnitude radix-4 restoring core with
// optional 16/8/4-bit leading-zero skipping and a valid/ready handshake.
module param_div
  import div_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int SKIP_EN = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_sign,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_quo,
  output logic [WIDTH-1:0] out_rem,
  output logic             out_dbz
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam int XW = 2 * WIDTH + 16;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [CW-1:0]    cnt_d;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] dvd_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] rem_d;
  logic [WIDTH-1:0] dvd_d;
  logic             quo_neg;
  logic             rem_neg;
  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic             accept;
  logic [XW-1:0]    pr_ext;
  logic [XW-1:0]    b_ext;
  logic [XW-1:0]    val16;
  logic [XW-1:0]    val8;
  logic [XW-1:0]    val4;
  logic [WIDTH+1:0] pr_r4;
  logic [WIDTH+1:0] d1;
  logic [WIDTH+1:0] d2;
  logic [WIDTH+1:0] d3;
  logic [WIDTH-1:0] r4_rem;
  logic [1:0]       r4_q;

  assign a_neg     = in_sign & in_a[WIDTH-1];
  assign b_neg     = in_sign & in_b[WIDTH-1];
  assign a_mag     = a_neg ? -in_a : in_a;
  assign b_mag     = b_neg ? -in_b : in_b;
  assign in_ready  = (state == ST_IDLE) && !flush;
  assign accept    = in_valid && in_ready;
  assign out_valid = (state == ST_DONE);

  assign pr_r4 = {rem_q, dvd_q[WIDTH-1:WIDTH-2]};
  assign d1    = {2'b00, b_q};
  assign d2    = {1'b0, b_q, 1'b0};
  assign d3    = d1 + d2;

  div_r4_step #(.WIDTH(WIDTH)) u_step (
    .rem_in   (pr_r4),
    .d1       (d1),
    .d2       (d2),
    .d3       (d3),
    .rem_out  (r4_rem),
    .quo_bits (r4_q)
  );

  // The next k quotient bits are all zero exactly when the partial remainder
  // extended by the next k dividend bits is still below the divisor.
  always_comb begin
    pr_ext = {rem_q, dvd_q, 16'b0};
    b_ext  = {{(WIDTH + 16){1'b0}}, b_q};
    val16  = pr_ext >> (WIDTH + 16 - SKIP_16);
    val8   = pr_ext >> (WIDTH + 16 - SKIP_8);
    val4   = pr_ext >> (WIDTH + 16 - SKIP_4);
    rem_d  = r4_rem;
    dvd_d  = {dvd_q[WIDTH-3:0], r4_q};
    cnt_d  = CW'(int'(cnt) - 2);
    if (SKIP_EN != 0 && int'(cnt) >= SKIP_16 && val16 < b_ext) begin
      rem_d = WIDTH'(val16);
      dvd_d = dvd_q << SKIP_16;
      cnt_d = CW'(int'(cnt) - SKIP_16);
    end else if (SKIP_EN != 0 && int'(cnt) >= SKIP_8 && val8 < b_ext) begin
      rem_d = WIDTH'(val8);
      dvd_d = dvd_q << SKIP_8;
      cnt_d = CW'(int'(cnt) - SKIP_8);
    end else if (SKIP_EN != 0 && int'(cnt) >= SKIP_4 && val4 < b_ext) begin
      rem_d = WIDTH'(val4);
      dvd_d = dvd_q << SKIP_4;
      cnt_d = CW'(int'(cnt) - SKIP_4);
    end
  end

  // Datapath registers: loaded on accept, advanced every CALC cycle.
  always_ff @(posedge clk) begin
    if (accept) begin
      rem_q   <= '0;
      dvd_q   <= a_mag;
      b_q     <= b_mag;
      quo_neg <= a_neg ^ b_neg;
      rem_neg <= a_neg;
    end else if (state == ST_CALC) begin
      rem_q <= rem_d;
      dvd_q <= dvd_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      out_dbz <= 1'b0;
      out_quo <= '0;
      out_rem <= '0;
    end else if (flush) begin
      state <= ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            if (in_b == '0) begin
              state   <= ST_DONE;
              cnt     <= '0;
              out_quo <= '1;
              out_rem <= in_a;
              out_dbz <= 1'b1;
            end else begin
              state   <= ST_CALC;
              cnt     <= CW'(WIDTH);
              out_dbz <= 1'b0;
            end
          end
        end
        ST_CALC: begin
          cnt <= cnt_d;
          if (cnt_d == '0) begin
            state   <= ST_DONE;
            out_quo <= quo_neg ? -dvd_d : dvd_d;
            out_rem <= rem_neg ? -rem_d : rem_d;
          end
        end
        ST_DONE: begin
          if (out_ready) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_param_div.sv
// Bench for param_div: directed 32-bit cases on a non-skipping and a skipping
// instance, plus a randomized 16-bit sweep against an arithmetic model.
module tb_param_div;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic        rst_n, flush;
  logic        v32, s32, rdy_a, rdy_b;
  logic [31:0] a32, b32;
  logic        ir_a, ov_a, dbz_a, ir_b, ov_b, dbz_b;
  logic [31:0] q_a, r_a, q_b, r_b;
  logic        v16, s16, rdy_c;
  logic [15:0] a16, b16;
  logic        ir_c, ov_c, dbz_c;
  logic [15:0] q_c, r_c;

  param_div #(.WIDTH(32), .SKIP_EN(0)) u_ns (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(v32), .in_ready(ir_a),
    .in_a(a32), .in_b(b32), .in_sign(s32), .out_valid(ov_a), .out_ready(rdy_a),
    .out_quo(q_a), .out_rem(r_a), .out_dbz(dbz_a)
  );

  param_div #(.WIDTH(32), .SKIP_EN(1)) u_sk (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(v32), .in_ready(ir_b),
    .in_a(a32), .in_b(b32), .in_sign(s32), .out_valid(ov_b), .out_ready(rdy_b),
    .out_quo(q_b), .out_rem(r_b), .out_dbz(dbz_b)
  );

  param_div #(.WIDTH(16), .SKIP_EN(1)) u_w16 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(v16), .in_ready(ir_c),
    .in_a(a16), .in_b(b16), .in_sign(s16), .out_valid(ov_c), .out_ready(rdy_c),
    .out_quo(q_c), .out_rem(r_c), .out_dbz(dbz_c)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: plain integer division, truncating toward zero.
  task automatic ref16(input logic [15:0] a, input logic [15:0] b, input logic s,
                       output logic [15:0] eq, output logic [15:0] er, output logic edbz);
    longint sa, sb, qq, rr;
    if (b == 16'd0) begin
      eq = 16'hFFFF; er = a; edbz = 1'b1;
    end else begin
      if (s) begin
        sa = longint'($signed(a));
        sb = longint'($signed(b));
      end else begin
        sa = longint'(a);
        sb = longint'(b);
      end
      qq = sa / sb;
      rr = sa % sb;
      eq = qq[15:0];
      er = rr[15:0];
      edbz = 1'b0;
    end
  endtask

  // Called at posedge+1 with both 32-bit instances idle.
  task automatic run32(input string tag, input logic [31:0] a, input logic [31:0] b,
                       input logic s, input logic [31:0] eq, input logic [31:0] er,
                       input logic edbz, input int lat_a, input int max_lat_b);
    int lat;
    bit got_a, got_b;
    chk({tag, "_in_ready"}, {ir_a, ir_b}, 2'b11);
    v32 = 1'b1; a32 = a; b32 = b; s32 = s; rdy_a = 1'b1; rdy_b = 1'b1;
    @(posedge clk); #1;
    v32 = 1'b0;
    lat = 1; got_a = 0; got_b = 0;
    while ((!got_a || !got_b) && lat < 40) begin
      if (ov_a && !got_a) begin
        got_a = 1;
        chk({tag, "_quo_ns"}, q_a, eq);
        chk({tag, "_rem_ns"}, r_a, er);
        chk({tag, "_dbz_ns"}, dbz_a, edbz);
        chk({tag, "_lat_ns"}, lat, lat_a);
      end
      if (ov_b && !got_b) begin
        got_b = 1;
        chk({tag, "_quo_sk"}, q_b, eq);
        chk({tag, "_rem_sk"}, r_b, er);
        chk({tag, "_dbz_sk"}, dbz_b, edbz);
        chk({tag, "_lat_sk_ok"}, (lat <= max_lat_b), 1);
      end
      @(posedge clk); #1;
      lat++;
    end
    if (!got_a) chk({tag, "_timeout_ns"}, 0, 1);
    if (!got_b) chk({tag, "_timeout_sk"}, 0, 1);
  endtask

  task automatic watch_quiet(input string tag);
    bit seen;
    seen = 0;
    for (int i = 0; i < 25; i++) begin
      if (ov_a || ov_b) seen = 1;
      @(posedge clk); #1;
    end
    chk({tag, "_no_valid"}, seen, 0);
    chk({tag, "_idle"}, {ir_a, ir_b}, 2'b11);
  endtask

  task automatic start_and_wait3();
    v32 = 1'b1; a32 = 32'd100; b32 = 32'd7; s32 = 1'b0;
    @(posedge clk); #1;
    v32 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
    end
  endtask

  logic [15:0] ra, rb, eq16, er16;
  logic        rs, edbz16;
  int          mode;
  bit          done;

  initial begin
    rst_n = 1'b0; flush = 1'b0;
    v32 = 1'b0; a32 = '0; b32 = '0; s32 = 1'b0; rdy_a = 1'b0; rdy_b = 1'b0;
    v16 = 1'b0; a16 = '0; b16 = '0; s16 = 1'b0; rdy_c = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("rst_in_ready", {ir_a, ir_b, ir_c}, 3'b111);
    chk("rst_out_valid", {ov_a, ov_b, ov_c}, 3'b000);
    chk("rst_dbz", {dbz_a, dbz_b, dbz_c}, 3'b000);
    chk("rst_quo", {q_a, q_b}, 64'd0);
    chk("rst_rem", {r_a, r_b}, 64'd0);

    run32("u100_7", 32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 1'b0, 17, 17);
    run32("s_m7_2", 32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 17, 17);
    run32("min_m1", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'd0, 1'b0, 17, 17);
    run32("dbz", 32'h0000_1234, 32'd0, 1'b0, 32'hFFFF_FFFF, 32'h0000_1234, 1'b1, 1, 1);
    run32("u5_3", 32'd5, 32'd3, 1'b0, 32'd1, 32'd2, 1'b0, 17, 16);
    run32("u_big", 32'hFFFF_FFFF, 32'h0001_0000, 1'b0, 32'h0000_FFFF, 32'h0000_FFFF, 1'b0, 17, 17);

    // Back-pressure on the skipping instance.
    rdy_a = 1'b1; rdy_b = 1'b0;
    v32 = 1'b1; a32 = 32'd5; b32 = 32'd3; s32 = 1'b0;
    @(posedge clk); #1;
    v32 = 1'b0;
    done = 0;
    for (int i = 0; i < 40 && !done; i++) begin
      if (ov_b) done = 1;
      else begin
        @(posedge clk); #1;
      end
    end
    chk("bp_valid_seen", done, 1);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("bp_hold_valid", ov_b, 1);
      chk("bp_hold_quo", q_b, 32'd1);
      chk("bp_hold_rem", r_b, 32'd2);
      chk("bp_hold_in_ready", ir_b, 0);
    end
    rdy_b = 1'b1;
    @(posedge clk); #1;
    chk("bp_release", {ov_b, ir_b}, 2'b01);
    done = 0;
    for (int i = 0; i < 40 && !done; i++) begin
      if (ir_a) done = 1;
      else begin
        @(posedge clk); #1;
      end
    end
    chk("bp_ns_drained", done, 1);

    // Flush mid-calculation, with a competing request in the flush cycle.
    start_and_wait3();
    flush = 1'b1; v32 = 1'b1; a32 = 32'd50; b32 = 32'd3;
    chk("flush_in_ready_low", {ir_a, ir_b}, 2'b00);
    @(posedge clk); #1;
    flush = 1'b0; v32 = 1'b0;
    chk("flush_valid_low", {ov_a, ov_b}, 2'b00);
    watch_quiet("flush");
    run32("flush_next", 32'd9, 32'd4, 1'b0, 32'd2, 32'd1, 1'b0, 17, 17);

    // Reset mid-calculation.
    start_and_wait3();
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("mid_rst_ready", {ir_a, ir_b}, 2'b11);
    chk("mid_rst_outs", {ov_a, ov_b, dbz_a, dbz_b}, 4'b0000);
    chk("mid_rst_data", {q_a, r_a}, 64'd0);
    watch_quiet("mid_rst");
    run32("rst_next", 32'd9, 32'd4, 1'b0, 32'd2, 32'd1, 1'b0, 17, 17);

    // Randomized 16-bit sweep with random back-pressure.
    for (int t = 0; t < 150; t++) begin
      mode = int'($urandom_range(0, 9));
      ra = 16'($urandom);
      rb = 16'($urandom);
      rs = 1'($urandom_range(0, 1));
      case (mode)
        0:       rb = 16'd0;
        1:       begin ra = 16'h8000; rb = 16'hFFFF; rs = 1'b1; end
        2, 3:    rb = 16'($urandom_range(1, 15));
        4:       ra = 16'($urandom_range(0, 255));
        default: ;
      endcase
      ref16(ra, rb, rs, eq16, er16, edbz16);
      chk("sweep_in_ready", ir_c, 1);
      v16 = 1'b1; a16 = ra; b16 = rb; s16 = rs;
      @(posedge clk); #1;
      v16 = 1'b0;
      done = 0;
      for (int k = 0; k < 60 && !done; k++) begin
        rdy_c = 1'($urandom_range(0, 1));
        if (ov_c && rdy_c) begin
          chk("sweep_quo", q_c, eq16);
          chk("sweep_rem", r_c, er16);
          chk("sweep_dbz", dbz_c, edbz16);
          done = 1;
        end
        @(posedge clk); #1;
      end
      rdy_c = 1'b0;
      if (!done) chk("sweep_timeout", 0, 1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/param_div.md
PARAM_DIV -- requirements
Module: param_div

Interface
REQ-001 Parameter WIDTH, default 32, operand/result width; SHALL be even and >= 8.
REQ-002 Parameter SKIP_EN, default 1; 1 enables leading-zero skip of 16/8/4 bits, 0 disables it.
REQ-003 clk  input  1  sole clock; all state SHALL change on its rising edge.
REQ-004 rst_n  input  1  reset; synchronous, active-low.
REQ-005 flush  input  1  abort; discards any in-flight or completed result.
REQ-006 in_valid  input  1  request offered.
REQ-007 in_ready  output  1  block can accept a request.
REQ-008 in_a  input  WIDTH  dividend.
REQ-009 in_b  input  WIDTH  divisor.
REQ-010 in_sign  input  1  1 = signed two's-complement, 0 = unsigned.
REQ-011 out_valid  output  1  result available.
REQ-012 out_ready  input  1  consumer takes result.
REQ-013 out_quo  output  WIDTH  quotient.
REQ-014 out_rem  output  WIDTH  remainder.
REQ-015 out_dbz  output  1  divisor was zero.

Function
REQ-016 FSM states IDLE, CALC, DONE; in_ready SHALL equal (state==IDLE && !flush).
REQ-017 Accept when in_valid && in_ready: latch |a|, |b|, quotient sign (a_neg XOR b_neg), remainder sign (a_neg), dbz; a_neg = in_sign && in_a[WIDTH-1], likewise b_neg.
REQ-018 Accepted with in_b==0: next state DONE, out_quo all ones, out_rem = in_a unmodified, out_dbz=1.
REQ-019 Otherwise next state CALC, remaining-bit counter loaded with WIDTH.
REQ-020 Each CALC cycle SHALL do exactly one action, first applicable wins: skip 16, skip 8, skip 4 (requires SKIP_EN=1, remaining >= k, next k quotient bits all zero; shift partial remainder/dividend left k, remaining -= k), else one radix-4 step (2 quotient bits from divisor multiples 1x/2x/3x, remaining -= 2).
REQ-021 CALC -> DONE in the cycle remaining reaches 0.
REQ-022 Internal subtraction width WIDTH+3 bits; no intermediate SHALL truncate.
REQ-023 In DONE: out_valid=1; out_quo/out_rem = magnitudes negated per latched signs; outputs SHALL stay stable until handshake.
REQ-024 out_valid && out_ready -> IDLE next cycle; new request accepted no earlier than the following cycle.
REQ-025 Signed MIN / -1 SHALL give quo=MIN, rem=0, out_dbz=0, no other flag.
REQ-026 Latency with SKIP_EN=0, b!=0: out_valid rises exactly WIDTH/2+1 cycles after the accept edge; with b==0: 1 cycle; with SKIP_EN=1: <= WIDTH/2+1 cycles.
REQ-027 flush in any state: next state IDLE, out_valid=0 next cycle; in_valid with flush in the same cycle SHALL not be accepted.
REQ-028 out_valid SHALL be 0 in IDLE and CALC.

Reset
REQ-029 rst_n low at a clock edge: state IDLE, counter 0, out_valid 0, out_dbz 0, out_quo/out_rem 0, regardless of prior state (mid-CALC included).
REQ-030 in_ready SHALL be 1 in the first cycle after reset release.

Structure
REQ-031 Shared package div_pkg SHALL hold the FSM state enum and the skip-size constants (16/8/4).
REQ-032 One combinational sub-module div_r4_step (remainder, divisor multiples -> next remainder, 2 quotient bits); skip logic and FSM stay in param_div.

Verification
REQ-033 WIDTH=32, SKIP_EN=0, unsigned 100/7 -> quo 14, rem 2, out_valid at accept+17.
REQ-034 Signed -7/2 -> quo 0xFFFFFFFD (-3), rem 0xFFFFFFFF (-1); 0x80000000/0xFFFFFFFF signed -> quo 0x80000000, rem 0.
REQ-035 in_b=0, in_a=0x1234 -> out_dbz=1, quo 0xFFFFFFFF, rem 0x1234, out_valid at accept+1.
REQ-036 SKIP_EN=1, 5/3 unsigned -> quo 1, rem 2, latency < 17; out_ready held low 5 cycles -> outputs constant, in_ready 0.
REQ-037 flush or rst_n low 3 cycles into CALC -> out_valid never rises for that request; next request 9/4 -> quo 2, rem 1.
REQ-038 WIDTH=16 random signed/unsigned sweep vs. reference model, random out_ready back-pressure, all results match.
